// File: rtl/ddr_burst_pkg.sv
// ============================================================================
// ddr_burst_pkg : shared encodings and types for the DDR burst command engine
// Revision      : 1.0
// ============================================================================
`default_nettype none

package ddr_burst_pkg;

   localparam int ADDR_W        = 29;
   localparam int DATA_W        = 256;
   localparam int DEF_ADDR_STEP = 8;

   localparam logic [2:0] ST_INIT     = 3'd0;
   localparam logic [2:0] ST_IDLE     = 3'd1;
   localparam logic [2:0] ST_WR       = 3'd2;
   localparam logic [2:0] ST_RD       = 3'd3;
   localparam logic [2:0] ST_RD_DRAIN = 3'd4;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

endpackage

`default_nettype wire

// File: rtl/ddr_burst_addr_gen.sv
// ============================================================================
// ddr_burst_addr_gen : loadable beat address/count generator with last flags
// Revision           : 1.0
// ============================================================================
`default_nettype none

module ddr_burst_addr_gen
   import ddr_burst_pkg::*;
#(
   parameter int ADDR_STEP = DEF_ADDR_STEP,
   parameter int LEN_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [LEN_W-1:0]  i_beats,
   input  logic              i_adv,
   output logic [ADDR_W-1:0] o_addr,
   output logic [LEN_W-1:0]  o_beats,
   output logic              o_last,
   output logic              o_all
);

   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_cnt;
   logic [LEN_W-1:0]  r_beats;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_cnt   <= '0;
         r_beats <= '0;
      end else if (i_load) begin
         r_addr  <= i_base;
         r_cnt   <= '0;
         r_beats <= i_beats;
      end else if (i_adv) begin
         r_addr <= r_addr + ADDR_W'(ADDR_STEP);
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   // Extra bit keeps the compare correct when the burst is the maximum length.
   assign o_last  = ({1'b0, r_cnt} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, r_beats};
   assign o_all   = (r_cnt == r_beats);
   assign o_addr  = r_addr;
   assign o_beats = r_beats;

endmodule

`default_nettype wire

// File: rtl/ddr_burst_ctrl.sv
// ============================================================================
// ddr_burst_ctrl : one-at-a-time write/read burst engine in front of a DDR UI
// Revision       : 1.0
// ============================================================================
`default_nettype none

module ddr_burst_ctrl
   import ddr_burst_pkg::*;
#(
   parameter int ADDR_STEP       = DEF_ADDR_STEP,
   parameter int LEN_W           = 16,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_wr_start,
   input  logic [ADDR_W-1:0] i_wr_base_addr,
   input  logic [LEN_W-1:0]  i_wr_beats,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_wr_data_valid,
   output logic              o_wr_data_rdy,
   output logic              o_wr_done,
   input  logic              i_rd_start,
   input  logic [ADDR_W-1:0] i_rd_base_addr,
   input  logic [LEN_W-1:0]  i_rd_beats,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_data_valid,
   output logic              o_rd_done,
   output logic              o_busy,
   output logic [2:0]        o_app_cmd,
   output logic              o_app_en,
   output logic [ADDR_W-1:0] o_app_addr,
   output logic [DATA_W-1:0] o_app_wdf_data,
   input  logic [DATA_W-1:0] i_app_rd_data,
   input  logic              i_app_rd_data_valid,
   input  logic              i_app_rdy,
   input  logic              i_app_wdf_rdy,
   input  logic              i_phy_init_done
);

   localparam int               OUT_W     = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [OUT_W-1:0] c_MAX_OUT = OUT_W'(MAX_OUTSTANDING);

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic              r_wr_pend;
   logic [ADDR_W-1:0] r_wr_pend_addr;
   logic [LEN_W-1:0]  r_wr_pend_beats;
   logic              r_rd_pend;
   logic [ADDR_W-1:0] r_rd_pend_addr;
   logic [LEN_W-1:0]  r_rd_pend_beats;
   logic [OUT_W-1:0]  r_outst;
   logic [LEN_W-1:0]  r_ret;
   logic              r_wr_done;
   logic              r_rd_done;
   logic              r_rd_valid;
   logic [DATA_W-1:0] r_rd_data;

   logic              w_idle, w_in_wr, w_in_rd, w_rd_active;
   logic              w_wr_go, w_rd_go, w_wr_cap, w_rd_cap;
   logic [ADDR_W-1:0] w_wr_base, w_rd_base;
   logic [LEN_W-1:0]  w_wr_len, w_rd_len;
   logic [ADDR_W-1:0] w_wg_addr, w_rg_addr;
   logic [LEN_W-1:0]  w_wg_beats, w_rg_beats;
   logic              w_wg_last, w_wg_all, w_rg_last, w_rg_all;
   logic              w_wr_rdy, w_wr_fire, w_wr_end;
   logic              w_rd_issue, w_rd_ret, w_ret_last;

   assign w_idle      = (r_state == ST_IDLE);
   assign w_in_wr     = (r_state == ST_WR);
   assign w_in_rd     = (r_state == ST_RD);
   assign w_rd_active = w_in_rd | (r_state == ST_RD_DRAIN);

   // A pending request takes priority over a same-cycle pulse; writes beat reads.
   assign w_wr_go   = w_idle & (r_wr_pend | i_wr_start);
   assign w_rd_go   = w_idle & ~w_wr_go & (r_rd_pend | i_rd_start);
   assign w_wr_base = r_wr_pend ? r_wr_pend_addr  : i_wr_base_addr;
   assign w_wr_len  = r_wr_pend ? r_wr_pend_beats : i_wr_beats;
   assign w_rd_base = r_rd_pend ? r_rd_pend_addr  : i_rd_base_addr;
   assign w_rd_len  = r_rd_pend ? r_rd_pend_beats : i_rd_beats;
   assign w_wr_cap  = i_wr_start & (w_wr_go ? r_wr_pend : ~r_wr_pend);
   assign w_rd_cap  = i_rd_start & (w_rd_go ? r_rd_pend : ~r_rd_pend);

   assign w_wr_rdy   = w_in_wr & ~w_wg_all & i_app_rdy & i_app_wdf_rdy;
   assign w_wr_fire  = w_wr_rdy & i_wr_data_valid;
   assign w_wr_end   = w_in_wr & (w_wg_all | (w_wr_fire & w_wg_last));
   assign w_rd_issue = w_in_rd & ~w_rg_all & i_app_rdy & (r_outst < c_MAX_OUT);
   assign w_rd_ret   = w_rd_active & i_app_rd_data_valid;
   assign w_ret_last = ({1'b0, r_ret} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, w_rg_beats};

   ddr_burst_addr_gen #(.ADDR_STEP(ADDR_STEP), .LEN_W(LEN_W)) u_wr_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_wr_go),
      .i_base  (w_wr_base),
      .i_beats (w_wr_len),
      .i_adv   (w_wr_fire),
      .o_addr  (w_wg_addr),
      .o_beats (w_wg_beats),
      .o_last  (w_wg_last),
      .o_all   (w_wg_all)
   );

   ddr_burst_addr_gen #(.ADDR_STEP(ADDR_STEP), .LEN_W(LEN_W)) u_rd_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_rd_go),
      .i_base  (w_rd_base),
      .i_beats (w_rd_len),
      .i_adv   (w_rd_issue),
      .o_addr  (w_rg_addr),
      .o_beats (w_rg_beats),
      .o_last  (w_rg_last),
      .o_all   (w_rg_all)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT:     if (i_phy_init_done) w_state_nxt = ST_IDLE;
         ST_IDLE: begin
            if (w_wr_go)      w_state_nxt = ST_WR;
            else if (w_rd_go) w_state_nxt = ST_RD;
         end
         ST_WR:       if (w_wr_end) w_state_nxt = ST_IDLE;
         // An empty read burst skips the drain phase entirely.
         ST_RD: begin
            if (w_rg_all)                     w_state_nxt = ST_IDLE;
            else if (w_rd_issue && w_rg_last) w_state_nxt = ST_RD_DRAIN;
         end
         ST_RD_DRAIN: if (r_ret == w_rg_beats) w_state_nxt = ST_IDLE;
         default:     w_state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_INIT;
         r_wr_pend       <= 1'b0;
         r_wr_pend_addr  <= '0;
         r_wr_pend_beats <= '0;
         r_rd_pend       <= 1'b0;
         r_rd_pend_addr  <= '0;
         r_rd_pend_beats <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_wr_pend <= w_wr_cap | (r_wr_pend & ~w_wr_go);
         r_rd_pend <= w_rd_cap | (r_rd_pend & ~w_rd_go);
         if (w_wr_cap) begin
            r_wr_pend_addr  <= i_wr_base_addr;
            r_wr_pend_beats <= i_wr_beats;
         end
         if (w_rd_cap) begin
            r_rd_pend_addr  <= i_rd_base_addr;
            r_rd_pend_beats <= i_rd_beats;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outst    <= '0;
         r_ret      <= '0;
         r_wr_done  <= 1'b0;
         r_rd_done  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         if (w_rd_go)
            r_outst <= '0;
         else if (w_rd_issue && !w_rd_ret)
            r_outst <= r_outst + 1'b1;
         else if (!w_rd_issue && w_rd_ret && (r_outst != '0))
            r_outst <= r_outst - 1'b1;

         if (w_rd_go)       r_ret <= '0;
         else if (w_rd_ret) r_ret <= r_ret + 1'b1;

         r_wr_done  <= w_wr_end;
         r_rd_done  <= (w_rd_ret & w_ret_last) | (w_in_rd & w_rg_all);
         r_rd_valid <= w_rd_ret;
         if (w_rd_ret) r_rd_data <= i_app_rd_data;
      end
   end

   assign o_wr_data_rdy   = w_wr_rdy;
   assign o_wr_done       = r_wr_done;
   assign o_rd_data       = r_rd_data;
   assign o_rd_data_valid = r_rd_valid;
   assign o_rd_done       = r_rd_done;
   assign o_busy          = w_in_wr | w_rd_active | r_wr_pend | r_rd_pend;
   assign o_app_en        = w_wr_fire | w_rd_issue;
   assign o_app_cmd       = w_in_wr ? CMD_WR : CMD_RD;
   assign o_app_addr      = w_in_wr ? w_wg_addr : (w_in_rd ? w_rg_addr : '0);
   assign o_app_wdf_data  = w_in_wr ? i_wr_data : '0;

endmodule

`default_nettype wire
